// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler
//   Sole owner of the XADC Wizard DRP port. Periodically issues a single-cycle
//   DRP read of one auxiliary channel, waits for drdy with a timeout, averages
//   2^AVG_LOG2 12-bit conversion codes and presents each average with a
//   one-cycle valid strobe for the downstream parser/duty stage.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   drp_den_o       DRP enable, one-cycle pulse per read
//   drp_daddr_o     DRP address, constant DADDR
//   drp_dwe_o       DRP write enable, constant 0
//   drp_di_o        DRP write data, constant 0
//   drp_do_i        DRP read data, conversion code in [15:4]
//   drp_drdy_i      DRP data-ready strobe
//   err_clr_i       clears both sticky error flags
//   sample_code_o   latest averaged code
//   sample_valid_o  one-cycle strobe when sample_code_o updates
//   timeout_err_o   sticky: drdy missing for TIMEOUT clocks
//   overrun_err_o   sticky: poll tick arrived while a read was in progress
//
// Optional feature (macro XADC_MINMAX_EN)
//   Adds sample_min_o / sample_max_o: minimum and maximum raw code of the
//   completed window, updated together with sample_code_o.

module xadc_drp_sampler #(
    parameter int unsigned POLL_PERIOD = 60000,
    parameter logic [6:0]  DADDR       = 7'h15,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        drp_den_o,
    output logic [6:0]  drp_daddr_o,
    output logic        drp_dwe_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    input  logic        err_clr_i,
    output logic [11:0] sample_code_o,
    output logic        sample_valid_o,
    output logic        timeout_err_o,
`ifdef XADC_MINMAX_EN
    output logic [11:0] sample_min_o,
    output logic [11:0] sample_max_o,
`endif
    output logic        overrun_err_o
);

    localparam int unsigned AccW       = 12 + AVG_LOG2;
    localparam int unsigned NumSamples = 1 << AVG_LOG2;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [15:0]     period_q, period_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [7:0]      tmo_q, tmo_d;
    logic [7:0]      tmo_inc;
    logic [11:0]     code_q, code_d;
    logic            valid_q, valid_d;
    logic            tmo_err_q, tmo_err_d;
    logic            ovr_err_q, ovr_err_d;
    logic            tick;
    logic [11:0]     raw_code;
`ifdef XADC_MINMAX_EN
    logic [11:0]     win_min_q, win_min_d;
    logic [11:0]     win_max_q, win_max_d;
    logic [11:0]     min_q, min_d;
    logic [11:0]     max_q, max_d;
`endif

    // Status register low nibble carries no conversion data.
    logic unused_do_lsbs;
    assign unused_do_lsbs = ^drp_do_i[3:0];

    assign raw_code = drp_do_i[15:4];
    assign tick     = (period_q == 16'(POLL_PERIOD - 1));
    assign period_d = tick ? 16'd0 : period_q + 16'd1;
    assign tmo_inc  = tmo_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        tmo_err_d = tmo_err_q & ~err_clr_i;
        ovr_err_d = ovr_err_q & ~err_clr_i;
`ifdef XADC_MINMAX_EN
        win_min_d = win_min_q;
        win_max_d = win_max_q;
        min_d     = min_q;
        max_d     = max_q;
`endif

        // A tick outside IDLE is dropped; set beats a simultaneous clear.
        if (tick && (state_q != StIdle)) begin
            ovr_err_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                tmo_d   = 8'd0;
                state_d = StWait;
            end
            StWait: begin
                // drdy takes priority over a timeout in the same cycle.
                if (drp_drdy_i) begin
                    acc_d = acc_q + AccW'(raw_code);
                    cnt_d = cnt_q + 5'd1;
`ifdef XADC_MINMAX_EN
                    if (raw_code < win_min_q) win_min_d = raw_code;
                    if (raw_code > win_max_q) win_max_d = raw_code;
`endif
                    state_d = (cnt_q == 5'(NumSamples - 1)) ? StOut : StIdle;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == 8'(TIMEOUT)) begin
                        // Partial window is discarded.
                        tmo_err_d = 1'b1;
                        acc_d     = '0;
                        cnt_d     = 5'd0;
`ifdef XADC_MINMAX_EN
                        win_min_d = 12'hfff;
                        win_max_d = 12'h000;
`endif
                        state_d   = StIdle;
                    end
                end
            end
            StOut: begin
                code_d  = 12'(acc_q >> AVG_LOG2);
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = 5'd0;
`ifdef XADC_MINMAX_EN
                min_d     = win_min_q;
                max_d     = win_max_q;
                win_min_d = 12'hfff;
                win_max_d = 12'h000;
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            period_q  <= 16'd0;
            acc_q     <= '0;
            cnt_q     <= 5'd0;
            tmo_q     <= 8'd0;
            code_q    <= 12'd0;
            valid_q   <= 1'b0;
            tmo_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
`ifdef XADC_MINMAX_EN
            win_min_q <= 12'hfff;
            win_max_q <= 12'h000;
            min_q     <= 12'd0;
            max_q     <= 12'd0;
`endif
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            tmo_err_q <= tmo_err_d;
            ovr_err_q <= ovr_err_d;
`ifdef XADC_MINMAX_EN
            win_min_q <= win_min_d;
            win_max_q <= win_max_d;
            min_q     <= min_d;
            max_q     <= max_d;
`endif
        end
    end

    assign drp_den_o      = (state_q == StReq);
    assign drp_daddr_o    = DADDR;
    assign drp_dwe_o      = 1'b0;
    assign drp_di_o       = 16'h0000;
    assign sample_code_o  = code_q;
    assign sample_valid_o = valid_q;
    assign timeout_err_o  = tmo_err_q;
    assign overrun_err_o  = ovr_err_q;
`ifdef XADC_MINMAX_EN
    assign sample_min_o   = min_q;
    assign sample_max_o   = max_q;
`endif

endmodule
